// File: rtl/flappy_pkg.sv
// Shared constants and state encoding for the pipe scroller and the collision checker.
package flappy_pkg;

    localparam int unsigned SCREEN_W = 640;
    localparam int unsigned PIPE_W   = 80;
    localparam int unsigned GAP_H    = 100;
    localparam int unsigned GAP_MIN  = 60;
    localparam int unsigned BIRD_X   = 160;

    localparam logic [15:0] LFSR_SEED = 16'hACE1;
    localparam logic [15:0] LFSR_TAPS = 16'hB400;

    // Reset gap tops come from the seed's low byte and a fixed second value.
    localparam logic [9:0] Y_INIT      = 10'(GAP_MIN + 32'hE1);
    localparam logic [9:0] NEXT_Y_INIT = 10'(GAP_MIN + 32'hAC);

    typedef enum logic [1:0] {
        QIdle   = 2'd0,
        QRun    = 2'd1,
        QFrozen = 2'd2
    } state_e;

    function automatic logic [9:0] gap_from_bits(input logic [7:0] bits);
        return 10'(GAP_MIN) + {2'b00, bits};
    endfunction

endpackage

// File: rtl/gap_lfsr.sv
// 16-bit Galois LFSR used to pick pipe gap heights; exposes the low byte.
module gap_lfsr
    import flappy_pkg::*;
(
    input  logic       i_clk,
    input  logic       i_reseed,
    input  logic       i_en,
    output logic [7:0] o_gap_bits
);

    logic [15:0] r_lfsr;

    always_ff @(posedge i_clk) begin
        if (i_reseed) begin
            r_lfsr <= LFSR_SEED;
        end else if (i_en) begin
            r_lfsr <= r_lfsr[0] ? ((r_lfsr >> 1) ^ LFSR_TAPS) : (r_lfsr >> 1);
        end
    end

    assign o_gap_bits = r_lfsr[7:0];

endmodule

// File: rtl/pipe_scroller.sv
// Two-slot pipe queue: scrolls pipes left on each tick, retires them past the bird and scores.
module pipe_scroller
    import flappy_pkg::*;
#(
    parameter int unsigned PIPE_SPACING = 320,
    parameter int unsigned SCROLL_STEP  = 2,
    parameter int unsigned TICK_DIV     = 833333
) (
    input  logic       Clk,
    input  logic       reset,
    input  logic       Start,
    input  logic       Lose,
    input  logic       Ack,
    output logic [9:0] X_Edge,
    output logic [9:0] Y_Edge,
    output logic [9:0] Next_X_Edge,
    output logic [9:0] Next_Y_Edge,
    output logic [9:0] Score,
    output logic       Score_Pulse,
    output logic       Q_Idle,
    output logic       Q_Run,
    output logic       Q_Frozen
);

    localparam int unsigned   CntW     = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
    localparam logic [CntW-1:0] TickLast = CntW'(TICK_DIV - 1);
    localparam logic [9:0]    Step     = 10'(SCROLL_STEP);
    localparam logic [9:0]    Spacing  = 10'(PIPE_SPACING);
    localparam logic [9:0]    XInit    = 10'(SCREEN_W);
    localparam logic [9:0]    NxInit   = 10'(SCREEN_W + PIPE_SPACING);

    state_e          r_state;
    logic [9:0]      r_x;
    logic [9:0]      r_y;
    logic [9:0]      r_nx;
    logic [9:0]      r_ny;
    logic [9:0]      r_score;
    logic            r_pulse;
    logic [CntW-1:0] r_cnt;

    logic [7:0]      w_gap_bits;
    logic            w_tick;
    logic            w_clear;
    logic [9:0]      w_nx;
    logic [9:0]      w_nnx;
    logic [10:0]     w_right;

    gap_lfsr u_gap_lfsr (
        .i_clk      (Clk),
        .i_reseed   (reset),
        .i_en       (1'b1),
        .o_gap_bits (w_gap_bits)
    );

    assign w_tick  = (r_cnt == TickLast);
    assign w_nx    = r_x - Step;
    assign w_nnx   = r_nx - Step;
    // Right edge after the move, widened so the sum cannot wrap.
    assign w_right = {1'b0, w_nx} + 11'(PIPE_W);
    assign w_clear = (w_right < 11'(BIRD_X));

    always_ff @(posedge Clk) begin
        r_pulse <= 1'b0;
        if (reset || (r_state == QFrozen && Ack)) begin
            r_state <= QIdle;
            r_x     <= XInit;
            r_y     <= Y_INIT;
            r_nx    <= NxInit;
            r_ny    <= NEXT_Y_INIT;
            r_score <= '0;
            r_cnt   <= '0;
        end else begin
            case (r_state)
                QIdle: begin
                    if (Start) begin
                        r_state <= QRun;
                    end
                end
                QRun: begin
                    // Lose wins over a coincident tick: nothing moves or scores.
                    if (Lose) begin
                        r_state <= QFrozen;
                        r_cnt   <= '0;
                    end else if (w_tick) begin
                        r_cnt <= '0;
                        if (w_clear) begin
                            r_x     <= w_nnx;
                            r_y     <= r_ny;
                            r_nx    <= w_nnx + Spacing;
                            r_ny    <= gap_from_bits(w_gap_bits);
                            r_score <= (r_score == 10'h3FF) ? r_score : r_score + 10'd1;
                            r_pulse <= 1'b1;
                        end else begin
                            r_x  <= w_nx;
                            r_nx <= w_nnx;
                        end
                    end else begin
                        r_cnt <= r_cnt + CntW'(1);
                    end
                end
                QFrozen: begin
                    r_state <= QFrozen;
                end
                default: begin
                    r_state <= QIdle;
                end
            endcase
        end
    end

    assign X_Edge      = r_x;
    assign Y_Edge      = r_y;
    assign Next_X_Edge = r_nx;
    assign Next_Y_Edge = r_ny;
    assign Score       = r_score;
    assign Score_Pulse = r_pulse;
    assign Q_Idle      = (r_state == QIdle);
    assign Q_Run       = (r_state == QRun);
    assign Q_Frozen    = (r_state == QFrozen);

endmodule

// File: tb/tb_pipe_scroller.sv
// Bench for pipe_scroller: scenario tasks checked against a behavioural pipe-queue model.
module tb_pipe_scroller;

    localparam int TD   = 2;
    localparam int STEP = 2;
    localparam int SP   = 320;
    localparam logic [53:0] RST_VEC =
        {10'd640, 10'd285, 10'd960, 10'd232, 10'd0, 1'b0, 1'b1, 1'b0, 1'b0};

    logic Clk = 1'b0;
    logic reset = 1'b1;
    logic Start = 1'b0;
    logic Lose = 1'b0;
    logic Ack = 1'b0;
    logic f_start = 1'b0;

    logic [9:0] X_Edge, Y_Edge, Next_X_Edge, Next_Y_Edge, Score;
    logic       Score_Pulse, Q_Idle, Q_Run, Q_Frozen;
    logic [9:0] f_x, f_y, f_nx, f_ny, f_score;
    logic       f_pulse, f_idle, f_run, f_frozen;

    int n_checks = 0;
    int n_fail = 0;

    always #5 Clk = ~Clk;

    pipe_scroller #(.PIPE_SPACING(SP), .SCROLL_STEP(STEP), .TICK_DIV(TD)) dut (
        .Clk(Clk), .reset(reset), .Start(Start), .Lose(Lose), .Ack(Ack),
        .X_Edge(X_Edge), .Y_Edge(Y_Edge), .Next_X_Edge(Next_X_Edge),
        .Next_Y_Edge(Next_Y_Edge), .Score(Score), .Score_Pulse(Score_Pulse),
        .Q_Idle(Q_Idle), .Q_Run(Q_Run), .Q_Frozen(Q_Frozen)
    );

    // Fast-scrolling instance: a pipe clears every 4 clocks, so saturation is reachable.
    pipe_scroller #(.PIPE_SPACING(320), .SCROLL_STEP(80), .TICK_DIV(1)) dut_fast (
        .Clk(Clk), .reset(reset), .Start(f_start), .Lose(1'b0), .Ack(1'b0),
        .X_Edge(f_x), .Y_Edge(f_y), .Next_X_Edge(f_nx), .Next_Y_Edge(f_ny),
        .Score(f_score), .Score_Pulse(f_pulse), .Q_Idle(f_idle), .Q_Run(f_run),
        .Q_Frozen(f_frozen)
    );

    // Reference model: 0 idle, 1 run, 2 frozen.
    int          m_mode, m_x, m_y, m_nx, m_ny, m_score, m_cnt;
    bit          m_pulse;
    logic [15:0] m_lfsr;

    function automatic logic [15:0] lfsr_next(input logic [15:0] g);
        return g[0] ? ((g >> 1) ^ 16'hB400) : (g >> 1);
    endfunction

    task automatic model_init();
        m_mode = 0; m_x = 640; m_y = 285; m_nx = 960; m_ny = 232;
        m_score = 0; m_cnt = 0;
    endtask

    task automatic model_step();
        logic [15:0] g;
        int nx, nnx;
        g = m_lfsr;
        m_pulse = 0;
        if (reset) begin
            model_init();
            m_lfsr = 16'hACE1;
        end else begin
            case (m_mode)
                0: if (Start) m_mode = 1;
                1: begin
                    if (Lose) begin
                        m_mode = 2;
                        m_cnt = 0;
                    end else if (m_cnt == TD - 1) begin
                        m_cnt = 0;
                        nx = m_x - STEP;
                        nnx = m_nx - STEP;
                        if (nx + 80 < 160) begin
                            m_x = nnx; m_y = m_ny; m_nx = nnx + SP;
                            m_ny = 60 + int'(g[7:0]);
                            if (m_score < 1023) m_score = m_score + 1;
                            m_pulse = 1;
                        end else begin
                            m_x = nx; m_nx = nnx;
                        end
                    end else begin
                        m_cnt = m_cnt + 1;
                    end
                end
                default: if (Ack) model_init();
            endcase
            m_lfsr = lfsr_next(g);
        end
    endtask

    always @(posedge Clk) model_step();

    function automatic logic [53:0] dut_vec();
        return {X_Edge, Y_Edge, Next_X_Edge, Next_Y_Edge, Score, Score_Pulse,
                Q_Idle, Q_Run, Q_Frozen};
    endfunction

    function automatic logic [53:0] exp_vec();
        return {10'(m_x), 10'(m_y), 10'(m_nx), 10'(m_ny), 10'(m_score), m_pulse,
                m_mode == 0, m_mode == 1, m_mode == 2};
    endfunction

    task automatic test_reset();
        @(negedge Clk);
        @(negedge Clk);
        reset = 1'b0;
        n_checks++;
        if (dut_vec() !== RST_VEC) begin
            n_fail++;
            $display("FAIL reset_values: got %h expected %h", dut_vec(), RST_VEC);
        end
        n_checks++;
        if (dut_vec() !== exp_vec()) begin
            n_fail++;
            $display("FAIL reset_model: got %h expected %h", dut_vec(), exp_vec());
        end
    endtask

    task automatic test_scroll();
        int xs[5] = '{640, 640, 638, 638, 636};
        int wait_n;
        wait_n = int'($urandom_range(0, 7));
        for (int i = 0; i < wait_n; i++) begin
            @(negedge Clk);
            n_checks++;
            if (dut_vec() !== exp_vec()) begin
                n_fail++;
                $display("FAIL idle_hold: got %h expected %h", dut_vec(), exp_vec());
            end
        end
        Start = 1'b1;
        @(negedge Clk);
        Start = 1'b0;
        n_checks++;
        if (Q_Run !== 1'b1) begin
            n_fail++;
            $display("FAIL start_to_run: got Q_Run=%b expected 1", Q_Run);
        end
        for (int i = 0; i < 5; i++) begin
            if (i > 0) @(negedge Clk);
            n_checks++;
            if (X_Edge !== 10'(xs[i]) || Next_X_Edge !== 10'(xs[i] + 320)) begin
                n_fail++;
                $display("FAIL scroll_step%0d: got X=%0d NX=%0d expected X=%0d NX=%0d",
                         i, X_Edge, Next_X_Edge, xs[i], xs[i] + 320);
            end
            n_checks++;
            if (dut_vec() !== exp_vec()) begin
                n_fail++;
                $display("FAIL scroll_model: got %h expected %h", dut_vec(), exp_vec());
            end
        end
    endtask

    task automatic test_clear();
        logic [9:0] old_ny;
        for (int i = 0; i < 1200 && X_Edge != 10'd80; i++) begin
            @(negedge Clk);
            n_checks++;
            if (dut_vec() !== exp_vec()) begin
                n_fail++;
                $display("FAIL run_model: got %h expected %h", dut_vec(), exp_vec());
            end
        end
        n_checks++;
        if (X_Edge !== 10'd80) begin
            n_fail++;
            $display("FAIL reach_x80: got X=%0d expected 80", X_Edge);
        end
        old_ny = Next_Y_Edge;
        for (int i = 0; i < 3 && X_Edge == 10'd80; i++) @(negedge Clk);
        n_checks++;
        if (X_Edge !== 10'd398 || Next_X_Edge !== 10'd718 || Y_Edge !== old_ny ||
            Score !== 10'd1 || Score_Pulse !== 1'b1) begin
            n_fail++;
            $display("FAIL clear_pipe: got X=%0d NX=%0d Y=%0d S=%0d P=%b expected 398 718 %0d 1 1",
                     X_Edge, Next_X_Edge, Y_Edge, Score, Score_Pulse, old_ny);
        end
        n_checks++;
        if (dut_vec() !== exp_vec()) begin
            n_fail++;
            $display("FAIL clear_model: got %h expected %h", dut_vec(), exp_vec());
        end
        @(negedge Clk);
        n_checks++;
        if (Score_Pulse !== 1'b0 || Score !== 10'd1) begin
            n_fail++;
            $display("FAIL pulse_width: got P=%b S=%0d expected 0 1", Score_Pulse, Score);
        end
    endtask

    task automatic test_lose_on_tick();
        logic [9:0] hold_x, hold_s;
        for (int i = 0; i < 4 && m_cnt != TD - 1; i++) @(negedge Clk);
        hold_x = X_Edge;
        hold_s = Score;
        Lose = 1'b1;
        @(negedge Clk);
        Lose = 1'b0;
        n_checks++;
        if (X_Edge !== hold_x || Q_Frozen !== 1'b1 || Score !== hold_s) begin
            n_fail++;
            $display("FAIL lose_on_tick: got X=%0d F=%b S=%0d expected X=%0d F=1 S=%0d",
                     X_Edge, Q_Frozen, Score, hold_x, hold_s);
        end
        for (int i = 0; i < 100; i++) begin
            Lose = 1'($urandom_range(0, 1));
            @(negedge Clk);
            n_checks++;
            if (Score !== hold_s || X_Edge !== hold_x || dut_vec() !== exp_vec()) begin
                n_fail++;
                $display("FAIL frozen_hold: got %h expected %h", dut_vec(), exp_vec());
            end
        end
        Lose = 1'b0;
    endtask

    task automatic test_ack();
        Start = 1'b1;
        @(negedge Clk);
        Start = 1'b0;
        n_checks++;
        if (Q_Frozen !== 1'b1) begin
            n_fail++;
            $display("FAIL start_in_frozen: got Q_Frozen=%b expected 1", Q_Frozen);
        end
        Ack = 1'b1;
        @(negedge Clk);
        Ack = 1'b0;
        n_checks++;
        if (dut_vec() !== RST_VEC) begin
            n_fail++;
            $display("FAIL ack_reinit: got %h expected %h", dut_vec(), RST_VEC);
        end
        n_checks++;
        if (dut_vec() !== exp_vec()) begin
            n_fail++;
            $display("FAIL ack_model: got %h expected %h", dut_vec(), exp_vec());
        end
    endtask

    task automatic test_saturate();
        int pulses = 0;
        f_start = 1'b1;
        @(negedge Clk);
        f_start = 1'b0;
        for (int i = 0; i < 6000 && pulses < 1025; i++) begin
            @(negedge Clk);
            if (f_pulse === 1'b1) begin
                pulses++;
                n_checks++;
                if (f_score !== 10'((pulses > 1023) ? 1023 : pulses)) begin
                    n_fail++;
                    $display("FAIL score_sat pulse %0d: got %0d expected %0d",
                             pulses, f_score, (pulses > 1023) ? 1023 : pulses);
                end
            end
        end
        n_checks++;
        if (pulses < 1025) begin
            n_fail++;
            $display("FAIL score_sat_pulses: got %0d pulses expected 1025", pulses);
        end
    endtask

    task automatic test_reset_mid_run();
        Start = 1'b1;
        @(negedge Clk);
        Start = 1'b0;
        for (int i = 0; i < 400 && X_Edge != 10'd500; i++) @(negedge Clk);
        n_checks++;
        if (X_Edge !== 10'd500) begin
            n_fail++;
            $display("FAIL reach_x500: got X=%0d expected 500", X_Edge);
        end
        reset = 1'b1;
        @(negedge Clk);
        reset = 1'b0;
        n_checks++;
        if (dut_vec() !== RST_VEC) begin
            n_fail++;
            $display("FAIL midrun_reset: got %h expected %h", dut_vec(), RST_VEC);
        end
        Start = 1'b1;
        @(negedge Clk);
        Start = 1'b0;
        @(negedge Clk);
        @(negedge Clk);
        n_checks++;
        if (X_Edge !== 10'd638 || Q_Run !== 1'b1 || dut_vec() !== exp_vec()) begin
            n_fail++;
            $display("FAIL restart_scroll: got X=%0d R=%b expected X=638 R=1", X_Edge, Q_Run);
        end
    endtask

    task automatic test_random();
        for (int i = 0; i < 4000; i++) begin
            Start = ($urandom_range(0, 9) == 0);
            Lose  = ($urandom_range(0, 799) == 0);
            Ack   = ($urandom_range(0, 19) == 0);
            reset = ($urandom_range(0, 1499) == 0);
            @(negedge Clk);
            n_checks++;
            if (dut_vec() !== exp_vec()) begin
                n_fail++;
                $display("FAIL random_model cyc %0d: got %h expected %h", i, dut_vec(), exp_vec());
            end
        end
        Start = 1'b0; Lose = 1'b0; Ack = 1'b0; reset = 1'b0;
    endtask

    initial begin
        model_init();
        m_lfsr = 16'hACE1;
        m_pulse = 0;
        test_reset();
        test_scroll();
        test_clear();
        test_lose_on_tick();
        test_ack();
        test_saturate();
        test_reset_mid_run();
        test_random();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
